// File: rtl/instr_word_encoder_pkg.sv
// Shared pipeline constants: MIPS opcodes/functs, instruction classes and the
// encoder state encoding. The ID-stage control decoder imports the same
// constants, so encoder and decoder cannot drift apart.
package pipe_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_OR   = 4'd3,
    CLS_SLT  = 4'd4,
    CLS_LW   = 4'd5,
    CLS_SW   = 4'd6,
    CLS_ADDI = 4'd7,
    CLS_BEQ  = 4'd8,
    CLS_J    = 4'd9
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_word_encoder_if.sv
// Instruction-in handshake plus imem write port and load status.
//   master : instruction source / imem+status sink (bench, boot loader)
//   slave  : the encoder
interface instr_word_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );

  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_word_encoder_field_pack.sv
// Combinational field packer: instruction class + register/immediate fields
// -> 32-bit MIPS word. Classes 10-15 flag illegal and produce a zero word.
//   cls      in  4   instruction class
//   rs/rt/rd in  5   register fields (rd used by R-type only)
//   imm      in  26  [15:0] I-type immediate, [25:0] J target
//   word     out 32  encoded instruction
//   illegal  out 1   class not encodable
module instr_field_pack
  import pipe_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      CLS_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      CLS_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
      CLS_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      CLS_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      CLS_LW:   word = {OPC_LW,   rs, rt, imm[15:0]};
      CLS_SW:   word = {OPC_SW,   rs, rt, imm[15:0]};
      CLS_ADDI: word = {OPC_ADDI, rs, rt, imm[15:0]};
      CLS_BEQ:  word = {OPC_BEQ,  rs, rt, imm[15:0]};
      CLS_J:    word = {OPC_J,    imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Streams encoded instructions into imem at consecutive word addresses.
//   clk, rst_n : clock, async active-low reset
//   start      : restart load at address 0, clear err/full
//   bus        : instruction handshake in, imem write + count/full/err out
// An accepted instruction is written one cycle later; count advances at the
// end of the write cycle, so the address for a new accept is count + any
// write currently on the bus.
module instr_word_encoder
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_word_encoder_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  enc_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic [ADDR_W:0]   count_nxt;
  logic              full_pending;
  logic              in_ready;
  logic              fire;

  instr_field_pack u_pack (
    .cls     (bus.in_class),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .imm     (bus.in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Words committed once the in-flight write (if any) lands.
  assign count_nxt    = count_q + (ADDR_W + 1)'(we_q);
  assign full_pending = (count_nxt == CNT_DEPTH);
  assign in_ready     = (state_q == ST_RUN) && !start && !full_pending;
  assign fire         = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_nxt;
    full_d  = full_q;
    err_d   = err_q;
    if (start) begin
      // A write already on the bus still completes but is not counted.
      state_d = ST_RUN;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (fire) begin
        if (pack_illegal) begin
          err_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          addr_d  = count_nxt[ADDR_W-1:0];
          wdata_d = pack_word;
        end
      end
      if (state_q == ST_RUN && we_q && count_q == CNT_LAST) begin
        state_d = ST_FULL;
        full_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder with a 4-word imem (ADDR_W=2) so the
// full boundary is reachable. Inputs change and outputs are sampled on the
// falling edge; every written word is also run through an independent
// opcode/funct decoder and checked against the class that was sent.
module tb_instr_word_encoder;

  localparam int AW = 2;

  logic clk;
  logic rst_n;
  logic start;
  int   n_chk;
  int   n_fail;

  instr_word_encoder_if #(.ADDR_W(AW)) bus ();

  instr_word_encoder #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-decoder view of a word: class number, 15 if unrecognised.
  function automatic int decode_cls(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    case (op)
      6'h00: case (fn)
               6'h20: return 0;
               6'h22: return 1;
               6'h24: return 2;
               6'h25: return 3;
               6'h2A: return 4;
               default: return 15;
             endcase
      6'h23: return 5;
      6'h2B: return 6;
      6'h08: return 7;
      6'h04: return 8;
      6'h02: return 9;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int cls, input int rs, input int rt, input int rd, input logic [25:0] imm);
    bus.in_valid = 1'b1;
    bus.in_class = 4'(cls);
    bus.in_rs    = 5'(rs);
    bus.in_rt    = 5'(rt);
    bus.in_rd    = 5'(rd);
    bus.in_imm   = imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_write(input string tag, input int addr, input logic [31:0] word, input int cls);
    chk({tag, "_we"},   64'(bus.imem_we), 64'd1);
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'(addr));
    chk({tag, "_data"}, 64'(bus.imem_wdata), 64'(word));
    chk({tag, "_dec"},  64'(decode_cls(bus.imem_wdata)), 64'(cls));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_class = '0;
    bus.in_rs    = '0;
    bus.in_rt    = '0;
    bus.in_rd    = '0;
    bus.in_imm   = '0;
    repeat (3) step();

    // Reset state
    chk("rst_we",    64'(bus.imem_we), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_addr",  64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_full",  64'(bus.full), 64'd0);
    chk("rst_err",   64'(bus.err), 64'd0);
    rst_n = 1'b1;

    // IDLE ignores in_valid
    drive(7, 1, 2, 0, 26'h5);
    #1 chk("idle_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("idle_we", 64'(bus.imem_we), 64'd0);
    idle();

    // 1: ADDI, latency 1, count after write
    pulse_start();
    drive(7, 1, 2, 31, 26'h0005);
    #1 chk("t1_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_write("t1_addi", 0, 32'h20220005, 7);
    chk("t1_cnt_during", 64'(bus.count), 64'd0);
    idle();
    step();
    chk("t1_we_off", 64'(bus.imem_we), 64'd0);
    chk("t1_count", 64'(bus.count), 64'd1);

    // 2: ADD then LW back-to-back
    pulse_start();
    chk("t2_count_clr", 64'(bus.count), 64'd0);
    drive(0, 1, 2, 3, 26'h0);
    step();
    check_write("t2_add", 0, 32'h00221820, 0);
    drive(5, 4, 5, 0, 26'h0008);
    step();
    check_write("t2_lw", 1, 32'h8C850008, 5);
    idle();
    step();
    chk("t2_count", 64'(bus.count), 64'd2);

    // 3: illegal class, then J
    pulse_start();
    drive(12, 3, 3, 3, 26'h3FF_FFFF);
    #1 chk("t3_ill_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("t3_ill_we", 64'(bus.imem_we), 64'd0);
    chk("t3_err", 64'(bus.err), 64'd1);
    chk("t3_ill_cnt", 64'(bus.count), 64'd0);
    drive(9, 7, 0, 0, 26'h0000010);
    step();
    check_write("t3_j", 0, 32'h08000010, 9);
    idle();
    step();
    chk("t3_err_hold", 64'(bus.err), 64'd1);
    chk("t3_count", 64'(bus.count), 64'd1);

    // Remaining R-type functs, filling the 4-word memory
    pulse_start();
    chk("r_err_clr", 64'(bus.err), 64'd0);
    drive(1, 5, 6, 7, 26'h0);
    step();
    check_write("r_sub", 0, 32'h00A63822, 1);
    drive(2, 8, 9, 10, 26'h0);
    step();
    check_write("r_and", 1, 32'h01095024, 2);
    drive(3, 31, 0, 1, 26'h0);
    step();
    check_write("r_or", 2, 32'h03E00825, 3);
    drive(4, 1, 1, 1, 26'h0);
    step();
    check_write("r_slt", 3, 32'h0021082A, 4);
    idle();
    step();
    chk("r_full", 64'(bus.full), 64'd1);

    // 4: stream 5 words into 4-word memory
    pulse_start();
    chk("t4_full_clr", 64'(bus.full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(7, 0, 0, 0, 26'(i));
      #1 chk($sformatf("t4_ready%0d", i), 64'(bus.in_ready), 64'd1);
      step();
      check_write($sformatf("t4_w%0d", i), i, 32'h20000000 | 32'(i), 7);
    end
    drive(7, 0, 0, 0, 26'd4);
    #1 chk("t4_ready_last", 64'(bus.in_ready), 64'd0);
    step();
    chk("t4_full", 64'(bus.full), 64'd1);
    chk("t4_we_held", 64'(bus.imem_we), 64'd0);
    chk("t4_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t4_count", 64'(bus.count), 64'd4);
    step();
    chk("t4_still_held", 64'(bus.imem_we), 64'd0);
    pulse_start();
    chk("t4_restart_full", 64'(bus.full), 64'd0);
    chk("t4_restart_err", 64'(bus.err), 64'd0);
    chk("t4_restart_cnt", 64'(bus.count), 64'd0);
    step();
    check_write("t4_w4", 0, 32'h20000004, 7);
    idle();
    step();
    chk("t4_count1", 64'(bus.count), 64'd1);

    // 5a: start with in_valid in the same cycle -> no accept
    start = 1'b1;
    drive(0, 1, 2, 3, 26'h0);
    step();
    start = 1'b0;
    idle();
    chk("t5_start_we", 64'(bus.imem_we), 64'd0);
    chk("t5_start_cnt", 64'(bus.count), 64'd0);

    // 5b: async reset during a write
    drive(6, 3, 7, 0, 26'hFFFC);
    step();
    check_write("t5_sw", 0, 32'hAC67FFFC, 6);
    drive(8, 2, 2, 0, 26'hFFFF);
    step();
    check_write("t5_beq", 1, 32'h1042FFFF, 8);
    chk("t5_cnt_pre", 64'(bus.count), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 64'(bus.imem_we), 64'd0);
    chk("t5_rst_cnt", 64'(bus.count), 64'd0);
    chk("t5_rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_post_we", 64'(bus.imem_we), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
